// File: rtl/cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_iter_ctrl
//
// Purpose:
//   Iteration controller for an iterative CORDIC cosine. One external
//   registered CORDIC stage (1-cycle latency, same clk/clk_en) is reused for
//   every iteration. This block sequences that stage, holds the target angle,
//   supplies the shift amount and the atan(2^-i) constant, seeds the first
//   iteration with (K, 0, 0) and captures the final x as the cosine.
//
// Ports:
//   clk, reset             sole rising-edge clock, synchronous active-high reset
//   clk_en                 global advance enable; low freezes all state
//   start, dataa           cosine request and its signed target angle (radians)
//   result, done, busy     signed cos(dataa), 1-cycle valid strobe, run flag
//   stg_target             target angle handed to the stage
//   stg_shift_value        iteration index i (shift amount)
//   stg_shift_angle        atan(2^-i) in fixed point
//   stg_angle/x/y          stage inputs for the current iteration
//   stg_new_angle/x/y      registered stage outputs fed back
//
// Handshake: start is a level sampled only in IDLE on an enabled edge while
//   done is low; there is no backpressure and no queuing. done is a one-cycle
//   valid strobe for result (it stretches only while clk_en is low), and result
//   holds until the next completed run.
//
// Configuration macro:
//   CORDIC_QUADRANT_FOLD_EN  when defined, angles with |dataa| > pi/2 are
//                            folded into range and the result is negated.
// -----------------------------------------------------------------------------
module cordic_iter_ctrl #(
  parameter int INTEGER_WIDTH        = 2,
  parameter int DECIMAL_WIDTH        = 20,
  parameter int DATA_WIDTH           = INTEGER_WIDTH + DECIMAL_WIDTH,
  parameter int CORDIC_COUNTER_WIDTH = 4,
  parameter int ITERATIONS           = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clk_en,
  input  logic                            start,
  input  logic [DATA_WIDTH-1:0]           dataa,
  output logic [DATA_WIDTH-1:0]           result,
  output logic                            done,
  output logic                            busy,
  output logic [DATA_WIDTH-1:0]           stg_target,
  output logic [CORDIC_COUNTER_WIDTH-1:0] stg_shift_value,
  output logic [DATA_WIDTH-1:0]           stg_shift_angle,
  output logic [DATA_WIDTH-1:0]           stg_angle,
  output logic [DATA_WIDTH-1:0]           stg_x,
  output logic [DATA_WIDTH-1:0]           stg_y,
  input  logic [DATA_WIDTH-1:0]           stg_new_angle,
  input  logic [DATA_WIDTH-1:0]           stg_new_x,
  input  logic [DATA_WIDTH-1:0]           stg_new_y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // CORDIC gain compensation 1/prod(sqrt(1+2^-2i)) in Q20.
  localparam logic [DATA_WIDTH-1:0] K_INIT = DATA_WIDTH'(636751);
  localparam logic [CORDIC_COUNTER_WIDTH-1:0] LAST_I =
    CORDIC_COUNTER_WIDTH'(ITERATIONS - 1);

  // round(atan(2^-i) * 2^20). Beyond i=15 atan(2^-i) equals 2^-i to well
  // under one LSB, so the plain shift is exact enough.
  function automatic logic [31:0] atan_q20(input int idx);
    case (idx)
      0:       return 32'd823550;
      1:       return 32'd486170;
      2:       return 32'd256879;
      3:       return 32'd130396;
      4:       return 32'd65451;
      5:       return 32'd32757;
      6:       return 32'd16383;
      7:       return 32'd8192;
      8:       return 32'd4096;
      9:       return 32'd2048;
      10:      return 32'd1024;
      11:      return 32'd512;
      12:      return 32'd256;
      13:      return 32'd128;
      14:      return 32'd64;
      15:      return 32'd32;
      default: return (32'd1 << DECIMAL_WIDTH) >> idx;
    endcase
  endfunction

  state_t                          r_state;
  state_t                          w_next_state;
  logic [CORDIC_COUNTER_WIDTH-1:0] r_i;
  logic [DATA_WIDTH-1:0]           r_target;
  logic                            r_fold;
  logic [DATA_WIDTH-1:0]           r_result;
  logic                            r_done;
  logic                            r_busy;
  logic                            w_accept;
  logic                            w_fold_in;
  logic [DATA_WIDTH-1:0]           w_target_in;

`ifdef CORDIC_QUADRANT_FOLD_EN
  // pi does not fit in DATA_WIDTH signed bits, so folding is done one bit wider.
  localparam logic signed [DATA_WIDTH:0] PI_Q      = (DATA_WIDTH+1)'(3294199);
  localparam logic signed [DATA_WIDTH:0] HALF_PI_Q = (DATA_WIDTH+1)'(1647099);

  logic signed [DATA_WIDTH:0] w_dataa_ext;
  logic signed [DATA_WIDTH:0] w_dataa_abs;

  assign w_dataa_ext = {dataa[DATA_WIDTH-1], dataa};
  assign w_dataa_abs = dataa[DATA_WIDTH-1] ? -w_dataa_ext : w_dataa_ext;
  assign w_fold_in   = (w_dataa_abs > HALF_PI_Q);
  // cos(pi - a) = -cos(a): fold into [-pi/2, pi/2] and negate on the way out.
  assign w_target_in = !w_fold_in           ? dataa :
                       dataa[DATA_WIDTH-1]  ? DATA_WIDTH'(-PI_Q - w_dataa_ext)
                                            : DATA_WIDTH'(PI_Q - w_dataa_ext);
`else
  assign w_fold_in   = 1'b0;
  assign w_target_in = dataa;
`endif

  // Next state and stage drive. Everything stage-facing is zero outside RUN.
  always_comb begin
    w_next_state    = r_state;
    w_accept        = 1'b0;
    stg_shift_value = '0;
    stg_shift_angle = '0;
    stg_angle       = '0;
    stg_x           = '0;
    stg_y           = '0;
    case (r_state)
      S_IDLE: begin
        // A start coinciding with the done strobe is dropped on purpose.
        if (start && !r_done) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        stg_shift_value = r_i;
        stg_shift_angle = DATA_WIDTH'(atan_q20(int'(r_i)));
        if (r_i == '0) begin
          stg_x = K_INIT;
        end else begin
          stg_x     = stg_new_x;
          stg_y     = stg_new_y;
          stg_angle = stg_new_angle;
        end
        if (r_i == LAST_I) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_target <= '0;
      r_fold   <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (clk_en) begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_target <= w_target_in;
            r_fold   <= w_fold_in;
            r_i      <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          r_i <= r_i + CORDIC_COUNTER_WIDTH'(1);
        end
        S_DONE: begin
          // The stage registered the last iteration on the edge into DONE.
          r_result <= r_fold ? ('0 - stg_new_x) : stg_new_x;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          // Clear so the stage sees an all-zero interface while idle.
          r_target <= '0;
          r_fold   <= 1'b0;
          r_i      <= '0;
        end
        default: begin
          r_i <= '0;
        end
      endcase
    end
  end

  assign result     = r_result;
  assign done       = r_done;
  assign busy       = r_busy;
  assign stg_target = r_target;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cordic_iter_ctrl
//
// Bench for cordic_iter_ctrl. Provides the external registered CORDIC stage,
// drives requests on the falling edge and samples there too. Expected results
// come from a plain iterative cosine model with its own atan table.
// -----------------------------------------------------------------------------
module tb_cordic_iter_ctrl;

  localparam int DW       = 22;
  localparam int CW       = 4;
  localparam int ITER     = 16;
  localparam int FRAC     = 20;
  localparam int K_VAL    = 636751;
  localparam int LATENCY  = ITER + 1;
  localparam int MAX_WAIT = 100;
  localparam int HALF_PI  = 1647099;
  localparam int TOL      = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk_en = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dataa = '0;
  logic [DW-1:0] result;
  logic          done;
  logic          busy;
  logic [DW-1:0] stg_target;
  logic [CW-1:0] stg_shift_value;
  logic [DW-1:0] stg_shift_angle;
  logic [DW-1:0] stg_angle;
  logic [DW-1:0] stg_x;
  logic [DW-1:0] stg_y;
  logic [DW-1:0] stg_new_angle = '0;
  logic [DW-1:0] stg_new_x = '0;
  logic [DW-1:0] stg_new_y = '0;

  int errors = 0;
  int checks = 0;
  int atan_tab[ITER];

  always #5 clk = ~clk;

  cordic_iter_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .clk_en          (clk_en),
    .start           (start),
    .dataa           (dataa),
    .result          (result),
    .done            (done),
    .busy            (busy),
    .stg_target      (stg_target),
    .stg_shift_value (stg_shift_value),
    .stg_shift_angle (stg_shift_angle),
    .stg_angle       (stg_angle),
    .stg_x           (stg_x),
    .stg_y           (stg_y),
    .stg_new_angle   (stg_new_angle),
    .stg_new_x       (stg_new_x),
    .stg_new_y       (stg_new_y)
  );

  function automatic int s2i(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Arithmetic shift right with round-half-up.
  function automatic int rsr(input int v, input int s);
    if (s == 0) return v;
    return (v + (1 << (s - 1))) >>> s;
  endfunction

  // ---------------- external CORDIC stage (rotation mode) ----------------
  always @(posedge clk) begin : stage_blk
    int x, y, z, t, s, a, dx, dy;
    if (clk_en) begin
      x  = s2i(stg_x);
      y  = s2i(stg_y);
      z  = s2i(stg_angle);
      t  = s2i(stg_target);
      a  = s2i(stg_shift_angle);
      s  = int'(stg_shift_value);
      dx = rsr(y, s);
      dy = rsr(x, s);
      if (z < t) begin
        stg_new_x     <= DW'(x - dx);
        stg_new_y     <= DW'(y + dy);
        stg_new_angle <= DW'(z + a);
      end else begin
        stg_new_x     <= DW'(x + dx);
        stg_new_y     <= DW'(y - dy);
        stg_new_angle <= DW'(z - a);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_cos(input int a);
    int  t, x, y, z, dx, dy;
    bit  neg;
    t   = a;
    neg = 1'b0;
`ifdef CORDIC_QUADRANT_FOLD_EN
    if (a > HALF_PI) begin
      t = 3294199 - a;
      neg = 1'b1;
    end else if (a < -HALF_PI) begin
      t = -3294199 - a;
      neg = 1'b1;
    end
`endif
    x = K_VAL;
    y = 0;
    z = 0;
    for (int i = 0; i < ITER; i++) begin
      dx = rsr(y, i);
      dy = rsr(x, i);
      if (z < t) begin
        x = x - dx; y = y + dy; z = z + atan_tab[i];
      end else begin
        x = x + dx; y = y - dy; z = z - atan_tab[i];
      end
    end
    return neg ? -x : x;
  endfunction

  function automatic int rand_angle();
`ifdef CORDIC_QUADRANT_FOLD_EN
    return int'($urandom_range(0, 4194303)) - 2097152;
`else
    return int'($urandom_range(0, 2 * HALF_PI)) - HALF_PI;
`endif
  endfunction

  // ---------------- driver ----------------
  // Issues one request and waits for done. lat counts edges after the
  // accepting edge; busy_cyc counts sampled cycles with busy high.
  task automatic run_one(input int angle, input int freeze_at, input int freeze_len,
                         input int extra_at, input int extra_angle,
                         output int lat, output int busy_cyc, output bit to);
    @(negedge clk);
    dataa = DW'(angle);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    to       = 1'b0;
    while (done !== 1'b1 && !to) begin
      if (busy === 1'b1) busy_cyc++;
      if (lat == extra_at) begin
        start = 1'b1;
        dataa = DW'(extra_angle);
      end else begin
        start = 1'b0;
      end
      if (lat == freeze_at) clk_en = 1'b0;
      if (lat == freeze_at + freeze_len) clk_en = 1'b1;
      @(negedge clk);
      lat++;
      if (lat > MAX_WAIT) to = 1'b1;
    end
    start  = 1'b0;
    clk_en = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clk_en = 1'b0;
    reset  = 1'b1;
    start  = 1'b1;
    dataa  = DW'(12345);
    repeat (2) @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0 (start in reset cycle must be ignored)", busy); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d expected 0", s2i(result)); end
    checks++;
    if ({stg_target, stg_shift_value, stg_shift_angle, stg_angle, stg_x, stg_y} !== '0) begin
      errors++;
      $display("FAIL reset_stg_zero: got tgt=%0d sh=%0d sa=%0d ang=%0d x=%0d y=%0d expected all 0",
               s2i(stg_target), stg_shift_value, s2i(stg_shift_angle), s2i(stg_angle), s2i(stg_x), s2i(stg_y));
    end
  endtask

  task automatic test_known(input string name, input int angle, input int ideal);
    int lat, bc, diff, exp_v;
    bit to;
    exp_v = model_cos(angle);
    run_one(angle, -1, 0, -1, 0, lat, bc, to);
    checks++;
    if (to || lat != LATENCY) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LATENCY); end
    checks++;
    if (bc != LATENCY) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bc, LATENCY); end
    checks++;
    if (s2i(result) != exp_v) begin errors++; $display("FAIL %s_result: got %0d expected %0d", name, s2i(result), exp_v); end
    diff = s2i(result) - ideal;
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > TOL) begin errors++; $display("FAIL %s_accuracy: got %0d expected %0d +/- %0d", name, s2i(result), ideal, TOL); end
    // A start while done is high must be dropped.
    start = 1'b1;
    dataa = DW'(angle);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: got done=%b busy=%b expected done=0 busy=0", name, done, busy);
    end
    checks++;
    if (stg_target !== '0) begin errors++; $display("FAIL %s_idle_target: got %0d expected 0", name, s2i(stg_target)); end
  endtask

  task automatic test_stage_interface();
    int angle, exp_v;
    logic [DW-1:0] ex, ey, ea;
    bit seen;
    angle = rand_angle();
    exp_v = model_cos(angle);
    @(negedge clk);
    dataa = DW'(angle);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < ITER; c++) begin
      ex = (c == 0) ? DW'(K_VAL) : stg_new_x;
      ey = (c == 0) ? '0 : stg_new_y;
      ea = (c == 0) ? '0 : stg_new_angle;
      checks++;
      if (stg_shift_value !== CW'(c) || stg_shift_angle !== DW'(atan_tab[c]) ||
          stg_x !== ex || stg_y !== ey || stg_angle !== ea || busy !== 1'b1) begin
        errors++;
        $display("FAIL stage_iter%0d: got sh=%0d sa=%0d x=%0d y=%0d ang=%0d busy=%b expected sh=%0d sa=%0d x=%0d y=%0d ang=%0d busy=1",
                 c, stg_shift_value, s2i(stg_shift_angle), s2i(stg_x), s2i(stg_y), s2i(stg_angle), busy,
                 c, atan_tab[c], s2i(ex), s2i(ey), s2i(ea));
      end
`ifndef CORDIC_QUADRANT_FOLD_EN
      checks++;
      if (stg_target !== DW'(angle)) begin errors++; $display("FAIL stage_target%0d: got %0d expected %0d", c, s2i(stg_target), angle); end
`endif
      @(negedge clk);
    end
    seen = 1'b0;
    for (int w = 0; w < 4 && !seen; w++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || s2i(result) != exp_v) begin
      errors++;
      $display("FAIL stage_result: got done=%b result=%0d expected done=1 result=%0d", done, s2i(result), exp_v);
    end
  endtask

  task automatic test_ignore_second();
    int a1, a2, lat, bc, exp_v;
    bit to;
    a1 = 300000;
    a2 = -1200000;
    exp_v = model_cos(a1);
    run_one(a1, -1, 0, 5, a2, lat, bc, to);
    checks++;
    if (to || lat != LATENCY) begin errors++; $display("FAIL ignore2_latency: got %0d expected %0d", lat, LATENCY); end
    checks++;
    if (s2i(result) != exp_v) begin errors++; $display("FAIL ignore2_result: got %0d expected %0d", s2i(result), exp_v); end
    @(negedge clk);
    repeat (LATENCY + 2) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore2_no_second_run: got done=%b busy=%b expected 0 0", done, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clk_en_freeze();
    int a, lat, bc, exp_v;
    bit to;
    logic [DW-1:0] held;
    a = -700000;
    exp_v = model_cos(a);
    run_one(a, 6, 5, -1, 0, lat, bc, to);
    checks++;
    if (to || lat != LATENCY + 5) begin errors++; $display("FAIL freeze_latency: got %0d expected %0d", lat, LATENCY + 5); end
    checks++;
    if (s2i(result) != exp_v) begin errors++; $display("FAIL freeze_result: got %0d expected %0d", s2i(result), exp_v); end
    // Freeze while done is high: done and result must hold.
    held   = DW'(exp_v);
    clk_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || result !== held) begin
        errors++;
        $display("FAIL freeze_done_hold: got done=%b result=%0d expected done=1 result=%0d", done, s2i(result), exp_v);
      end
    end
    clk_en = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL freeze_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_reset_mid_run();
    int a, lat, bc, exp_v;
    bit to;
    @(negedge clk);
    dataa = DW'(500000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL midreset_state: got busy=%b done=%b result=%0d expected 0 0 0", busy, done, s2i(result));
    end
    checks++;
    if (stg_x !== '0 || stg_target !== '0 || stg_shift_value !== '0) begin
      errors++;
      $display("FAIL midreset_stg: got x=%0d tgt=%0d sh=%0d expected 0 0 0", s2i(stg_x), s2i(stg_target), stg_shift_value);
    end
    a = -150000;
    exp_v = model_cos(a);
    run_one(a, -1, 0, -1, 0, lat, bc, to);
    checks++;
    if (to || lat != LATENCY || s2i(result) != exp_v) begin
      errors++;
      $display("FAIL midreset_rerun: got lat=%0d result=%0d expected lat=%0d result=%0d", lat, s2i(result), LATENCY, exp_v);
    end
  endtask

  task automatic test_random();
    int a, lat, bc, exp_v;
    bit to;
    for (int n = 0; n < 16; n++) begin
      a = rand_angle();
      exp_v = model_cos(a);
      run_one(a, -1, 0, -1, 0, lat, bc, to);
      checks++;
      if (to || lat != LATENCY || s2i(result) != exp_v) begin
        errors++;
        $display("FAIL random%0d angle=%0d: got lat=%0d result=%0d expected lat=%0d result=%0d",
                 n, a, lat, s2i(result), LATENCY, exp_v);
      end
    end
  endtask

  task automatic test_boundary();
    int vals[$];
    int lat, bc, exp_v;
    bit to;
    vals = '{HALF_PI, -HALF_PI, 1, -1};
`ifdef CORDIC_QUADRANT_FOLD_EN
    vals.push_back(HALF_PI + 1);
    vals.push_back(-HALF_PI - 1);
    vals.push_back(2097151);
    vals.push_back(-2097152);
`endif
    foreach (vals[k]) begin
      exp_v = model_cos(vals[k]);
      run_one(vals[k], -1, 0, -1, 0, lat, bc, to);
      checks++;
      if (to || lat != LATENCY || s2i(result) != exp_v) begin
        errors++;
        $display("FAIL boundary angle=%0d: got lat=%0d result=%0d expected lat=%0d result=%0d",
                 vals[k], lat, s2i(result), LATENCY, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, lat, bc, exp_v;
    bit to;
    // run_one starts on the cycle right after the previous done strobe.
    for (int n = 0; n < 4; n++) begin
      a = rand_angle();
      exp_v = model_cos(a);
      run_one(a, -1, 0, -1, 0, lat, bc, to);
      checks++;
      if (to || lat != LATENCY || s2i(result) != exp_v) begin
        errors++;
        $display("FAIL b2b%0d: got lat=%0d result=%0d expected lat=%0d result=%0d", n, lat, s2i(result), LATENCY, exp_v);
      end
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    real r;
    r = 1.0;
    for (int i = 0; i < ITER; i++) begin
      atan_tab[i] = $rtoi($atan(r) * (2.0 ** FRAC) + 0.5);
      r = r / 2.0;
    end
    test_reset();
    test_known("zero", 0, 1048576);
    test_known("pi4", 823550, 741455);
    test_stage_interface();
    test_ignore_second();
    test_clk_en_freeze();
    test_reset_mid_run();
    test_boundary();
    test_random();
    test_back_to_back();
`ifdef CORDIC_QUADRANT_FOLD_EN
    test_known("fold_pos", 1992294, -338993);
    test_known("fold_neg", -1992294, -338993);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_iter_ctrl.md
CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- INTEGER_WIDTH, 2, integer bits of the signed fixed-point format.
- DECIMAL_WIDTH, 20, fraction bits.
- DATA_WIDTH, INTEGER_WIDTH+DECIMAL_WIDTH, word width.
- CORDIC_COUNTER_WIDTH, 4, shift/iteration counter width.
- ITERATIONS, 16, number of CORDIC iterations, at most 2^CORDIC_COUNTER_WIDTH.

REQ-002 SHALL have one clock and a synchronous, active-high reset; ports, one per line, as name direction width meaning:
- clk in 1: sole clock, rising edge.
- reset in 1: synchronous, active-high.
- clk_en in 1: global advance enable; when low all state freezes.
- start in 1: request a cosine of dataa.
- dataa in DATA_WIDTH: signed target angle, radians.
- result out DATA_WIDTH: signed cos(dataa).
- done out 1: result valid strobe.
- busy out 1: high from start acceptance until done.
- stg_target out DATA_WIDTH: stage target.
- stg_shift_value out CORDIC_COUNTER_WIDTH: stage shift.
- stg_shift_angle out DATA_WIDTH: atan(2^-i) for the stage.
- stg_angle out DATA_WIDTH: stage angle input.
- stg_x out DATA_WIDTH: stage x input.
- stg_y out DATA_WIDTH: stage y input.
- stg_new_angle in DATA_WIDTH: registered stage angle output.
- stg_new_x in DATA_WIDTH: registered stage x output.
- stg_new_y in DATA_WIDTH: registered stage y output.

REQ-003 SHALL drive one external registered CORDIC stage with 1-cycle latency, clocked by the same clk/clk_en, reusing it for every iteration.

Function
REQ-004 SHALL implement states IDLE, RUN, DONE; all transitions occur only on clk edges with clk_en=1.
REQ-005 IDLE: start=1 -> latch dataa (after optional folding, REQ-016) into target register, clear counter i to 0, go to RUN, set busy=1.
REQ-006 In RUN, i=0 SHALL present stg_x=K=636751 (round(0.607252935*2^20)), stg_y=0, stg_angle=0.
REQ-007 In RUN, i>0 SHALL present stg_x/stg_y/stg_angle = stg_new_x/stg_new_y/stg_new_angle combinationally.
REQ-008 In RUN, stg_shift_value SHALL equal i, and stg_shift_angle SHALL be ROM[i] = round(atan(2^-i)*2^DECIMAL_WIDTH), with ROM[0]=823550 and ROM[1]=486170.
REQ-009 stg_target SHALL equal the target register at all times.
REQ-010 Each enabled RUN cycle SHALL increment i; at i=ITERATIONS-1 the next state is DONE.
REQ-011 DONE, one enabled cycle: result <= stg_new_x, negated if the fold flag is set; done=1 on the following cycle only; busy=0; next state is IDLE.
REQ-012 Latency: start sampled at edge E0 -> done high in the cycle after edge E(ITERATIONS+1), i.e. 17 enabled cycles by default.
REQ-013 start while busy=1, or in the same cycle done=1, SHALL be ignored; no queuing.
REQ-014 clk_en=0 SHALL hold state, i, result, done and busy; done stays high while frozen and is cleared on the next enabled edge.
REQ-015 result SHALL hold its value until the next DONE; arithmetic is two's complement at DATA_WIDTH, negation wraps with no saturation.

Configuration
REQ-016 Macro CORDIC_QUADRANT_FOLD_EN:
- Defined: |dataa| > pi/2 (1647099) is replaced by sign(dataa)*pi - dataa, with pi = 3294199 computed at DATA_WIDTH+1 bits; the fold flag is set and result is negated.
- Undefined: dataa is used unchanged, the fold flag is always 0, and behaviour is defined for |dataa| <= 1647099 only.

Reset
REQ-017 reset=1 at a clk edge (regardless of clk_en) SHALL force IDLE, i=0, target=0, fold flag=0, result=0, done=0, busy=0, aborting any run; start is not sampled in the reset cycle.
REQ-018 All stg_* outputs SHALL be 0 while in IDLE.

Verification
REQ-019 dataa=0, start pulse -> done after exactly 17 cycles, result within 2^20 +/-16.
REQ-020 dataa=823550 (pi/4) -> result within 741455 +/-16; done high for exactly 1 cycle; busy high for 17 cycles.
REQ-021 Second start 5 cycles after the first -> ignored; single done; result matches the first angle only.
REQ-022 clk_en held low for 5 cycles mid-run -> done delayed by exactly 5 cycles; result unchanged vs. the uninterrupted run.
REQ-023 reset asserted at RUN i=8 -> next cycle busy=0, done=0, result=0; a new start then completes normally in 17 cycles.
REQ-024 With CORDIC_QUADRANT_FOLD_EN, dataa=1992294 (1.9 rad) -> result within -338993 +/-16; dataa=-1992294 -> same result.
